// File: rtl/edge_timestamper.sv
// Edge capture front end of the delay line: synchronises sig_in, stamps
// each selected edge with count + delay and pushes it into the FIFO.
module edge_timestamper #(
  parameter int WIDTH     = 8,
  parameter int MIN_DELAY = 4,
  parameter int EDGE      = 0
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             sig_in,
  input  logic             en,
  input  logic [WIDTH-1:0] delay,
  input  logic             full,
  input  logic             clr_overflow,
  output logic             wr_req,
  output logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] count,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MIN_D = WIDTH'(MIN_DELAY);

  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  logic             fall;
  logic             hit;
  logic             take;
  logic             drop;
  logic [WIDTH-1:0] delay_eff;
  logic [WIDTH-1:0] due;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) count <= '0;
    else          count <= count + WIDTH'(1);
  end

  always_comb begin
    rise = s2 & ~s3;
    fall = ~s2 & s3;
    hit  = 1'b0;
    case (EDGE)
      0:       hit = rise;
      1:       hit = fall;
      default: hit = rise | fall;
    endcase
  end

  // Short delays are clamped so the comparator can fetch the entry in time
  always_comb begin
    delay_eff = (delay < MIN_D) ? MIN_D : delay;
    due       = count + delay_eff;
    take      = hit & en & ~full;
    drop      = hit & en & full;
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      wr_req  <= 1'b0;
      wr_data <= '0;
    end else begin
      wr_req <= take;
      if (take) wr_data <= due;
    end
  end

  // A drop on the same cycle as a clear leaves the flag set
  always_ff @(posedge clk) begin
    if (!n_reset)          overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_edge_timestamper.sv
// Randomised and directed bench for edge_timestamper, all three EDGE modes
// side by side against a cycle-level reference model.
module tb_edge_timestamper;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       sig_in = 1'b0;
  logic       en = 1'b1;
  logic [7:0] delay = 8'd0;
  logic       full = 1'b0;
  logic       clr_overflow = 1'b0;

  logic [2:0] wr_req_o;
  logic [7:0] wr_data_o [3];
  logic [7:0] count_o [3];
  logic [2:0] ovf_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_count;
  logic       m_req [3];
  logic [7:0] m_data [3];
  logic       m_ovf [3];
  // sig_in as sampled one, two and three edges ago
  logic       h1, h2, h3;
  int         pulses;

  always #5 clk = ~clk;

  edge_timestamper #(.WIDTH(8), .MIN_DELAY(4), .EDGE(0)) dut0 (
    .clk(clk), .n_reset(n_reset), .sig_in(sig_in), .en(en),
    .delay(delay), .full(full), .clr_overflow(clr_overflow),
    .wr_req(wr_req_o[0]), .wr_data(wr_data_o[0]),
    .count(count_o[0]), .overflow(ovf_o[0]));

  edge_timestamper #(.WIDTH(8), .MIN_DELAY(4), .EDGE(1)) dut1 (
    .clk(clk), .n_reset(n_reset), .sig_in(sig_in), .en(en),
    .delay(delay), .full(full), .clr_overflow(clr_overflow),
    .wr_req(wr_req_o[1]), .wr_data(wr_data_o[1]),
    .count(count_o[1]), .overflow(ovf_o[1]));

  edge_timestamper #(.WIDTH(8), .MIN_DELAY(4), .EDGE(2)) dut2 (
    .clk(clk), .n_reset(n_reset), .sig_in(sig_in), .en(en),
    .delay(delay), .full(full), .clr_overflow(clr_overflow),
    .wr_req(wr_req_o[2]), .wr_data(wr_data_o[2]),
    .count(count_o[2]), .overflow(ovf_o[2]));

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit rise, fall, hit, drop;
    int deff;
    if (!n_reset) begin
      m_count = 8'd0;
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
      for (int e = 0; e < 3; e++) begin
        m_req[e] = 1'b0; m_data[e] = 8'd0; m_ovf[e] = 1'b0;
      end
    end else begin
      rise = h2 && !h3;
      fall = !h2 && h3;
      deff = (int'(delay) < 4) ? 4 : int'(delay);
      for (int e = 0; e < 3; e++) begin
        hit = (e == 0) ? rise : (e == 1) ? fall : (rise || fall);
        drop = hit && en && full;
        m_req[e] = hit && en && !full;
        if (m_req[e]) m_data[e] = 8'((int'(m_count) + deff) % 256);
        if (drop) m_ovf[e] = 1'b1;
        else if (clr_overflow) m_ovf[e] = 1'b0;
      end
      h3 = h2; h2 = h1; h1 = sig_in;
      m_count = m_count + 8'd1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int e = 0; e < 3; e++) begin
      check($sformatf("count%0d", e), int'(count_o[e]), int'(m_count));
      check($sformatf("wr_req%0d", e), int'(wr_req_o[e]), int'(m_req[e]));
      check($sformatf("wr_data%0d", e), int'(wr_data_o[e]), int'(m_data[e]));
      check($sformatf("overflow%0d", e), int'(ovf_o[e]), int'(m_ovf[e]));
    end
    if (wr_req_o[0]) pulses++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until(input logic [7:0] target);
    int budget = 600;
    while (m_count != target && budget > 0) begin
      step();
      budget--;
    end
    check("run_until", int'(m_count), int'(target));
  endtask

  task automatic rise_at(input logic [7:0] hit_count, input logic [7:0] d);
    run_until(hit_count - 8'd2);
    sig_in = 1'b1;
    delay = d;
    steps(3);
  endtask

  initial begin
    n_reset = 1'b0;
    steps(2);
    check("reset_count", int'(count_o[0]), 0);
    n_reset = 1'b1;
    step();
    check("first_count", int'(count_o[0]), 1);
    steps(300);

    rise_at(8'd20, 8'd100);
    check("rise_req", int'(wr_req_o[0]), 1);
    check("rise_data", int'(wr_data_o[0]), 120);
    step();
    check("rise_pulse", int'(wr_req_o[0]), 0);
    sig_in = 1'b0;
    pulses = 0;
    steps(6);
    check("fall_nowrite", pulses, 0);

    rise_at(8'd250, 8'd10);
    check("wrap_data", int'(wr_data_o[0]), 4);
    sig_in = 1'b0;
    steps(5);
    rise_at(8'd50, 8'd1);
    check("clamp_data", int'(wr_data_o[0]), 54);

    sig_in = 1'b0;
    steps(5);
    full = 1'b1;
    sig_in = 1'b1;
    steps(3);
    check("drop_req", int'(wr_req_o[0]), 0);
    check("drop_ovf", int'(ovf_o[0]), 1);
    full = 1'b0;
    sig_in = 1'b0;
    steps(5);
    sig_in = 1'b1;
    steps(3);
    check("after_drop_req", int'(wr_req_o[0]), 1);
    check("ovf_sticky", int'(ovf_o[0]), 1);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check("ovf_clear", int'(ovf_o[0]), 0);

    sig_in = 1'b0;
    steps(5);
    clr_overflow = 1'b1;
    full = 1'b1;
    sig_in = 1'b1;
    steps(3);
    check("set_wins", int'(ovf_o[0]), 1);
    full = 1'b0;
    clr_overflow = 1'b0;

    en = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      sig_in = ~sig_in;
      delay = 8'($urandom);
      steps(2);
    end
    steps(4);
    check("en_low_nowrite", pulses, 0);
    check("en_low_ovf", int'(ovf_o[0]), 1);
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sig_in = ~sig_in;
      delay = 8'($urandom);
      steps(1 + int'($urandom_range(0, 2)));
    end
    steps(4);

    sig_in = 1'b0;
    steps(5);
    sig_in = 1'b1;
    step();
    n_reset = 1'b0;
    pulses = 0;
    step();
    n_reset = 1'b1;
    check("midreset_count", int'(count_o[0]), 0);
    steps(8);
    check("midreset_one_write", pulses, 1);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) sig_in = ~sig_in;
      en = ($urandom_range(0, 7) != 0);
      full = ($urandom_range(0, 4) == 0);
      clr_overflow = ($urandom_range(0, 9) == 0);
      delay = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 5))
                                          : 8'($urandom);
      n_reset = ($urandom_range(0, 199) != 0);
      step();
    end
    n_reset = 1'b1;
    steps(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
